// File: rtl/mod_counter_pkg.sv
// Shared constants and helpers for the modulo-N up/down counter family.
package mod_counter_pkg;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  // A divide-by-1 prescaler still needs a one-bit register to stay legal.
  function automatic int pre_width(input int div);
    return ($clog2(div) < 1) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/mod_counter_prescaler.sv
// Enable prescaler: emits one tick per DIV enabled cycles and holds its phase while en is low.
module mod_counter_prescaler
  import mod_counter_pkg::*;
#(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic Rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int              PW   = pre_width(DIV);
  localparam logic [PW-1:0]   LAST = PW'(DIV - 1);

  logic [PW-1:0] pre;

  assign tick = en && (pre == LAST);

  always_ff @(posedge clk) begin
    if (Rst || clr) begin
      pre <= '0;
    end else if (tick) begin
      pre <= '0;
    end else if (en) begin
      pre <= pre + PW'(1);
    end
  end

endmodule

// File: rtl/mod_updown_counter.sv
// Modulo-MOD up/down counter with prescaled enable, parallel load and tc/load_err pulses.
// Define MOD_COUNTER_SAT_EN to saturate at 0 and MOD-1 instead of wrapping.
module mod_updown_counter
  import mod_counter_pkg::*;
#(
  parameter int WIDTH = 3,
  parameter int MOD   = 8,
  parameter int DIV   = 1
) (
  input  logic             clk,
  input  logic             Rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] out,
  output logic             tc,
  output logic             load_err
);

  localparam logic [WIDTH-1:0] MAX = WIDTH'(MOD - 1);

  logic             tick;
  logic [WIDTH-1:0] out_nxt;
  logic             tc_nxt;
  logic             err_nxt;

  mod_counter_prescaler #(.DIV(DIV)) u_pre (
    .clk  (clk),
    .Rst  (Rst),
    .clr  (load),
    .en   (en),
    .tick (tick)
  );

  // Bounds are compared explicitly so a MOD below 2**WIDTH never relies on overflow.
  always_comb begin
    out_nxt = out;
    tc_nxt  = 1'b0;
    err_nxt = 1'b0;
    if (load) begin
      if (load_val <= MAX) begin
        out_nxt = load_val;
      end else begin
        out_nxt = MAX;
        err_nxt = 1'b1;
      end
    end else if (tick) begin
      if (up_dn == DIR_UP) begin
        if (out == MAX) begin
          tc_nxt = 1'b1;
`ifdef MOD_COUNTER_SAT_EN
          out_nxt = MAX;
`else
          out_nxt = '0;
`endif
        end else begin
          out_nxt = out + WIDTH'(1);
        end
      end else begin
        if (out == '0) begin
          tc_nxt = 1'b1;
`ifdef MOD_COUNTER_SAT_EN
          out_nxt = '0;
`else
          out_nxt = MAX;
`endif
        end else begin
          out_nxt = out - WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (Rst) begin
      out      <= '0;
      tc       <= 1'b0;
      load_err <= 1'b0;
    end else begin
      out      <= out_nxt;
      tc       <= tc_nxt;
      load_err <= err_nxt;
    end
  end

endmodule
